adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 76 +++++++
 tb/tb_adder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered two-operand adder with a valid/ready stream on both sides.
// A main output register feeds the downstream port and a single skid
// register absorbs the one result that can arrive while the output is
// stalled, so upstream ready is a pure register (no combinational path
// from o_ack or i_req back to i_ack).
//
// Handshake: a word moves on a rising clk edge where the sender's req and
// the receiver's ack are both 1. A sender holds req and data steady until
// the transfer happens; a receiver may drive ack independently of req.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_datb,
  output logic             i_ack,
  output logic             o_req,
  output logic [WIDTH-1:0] o_datc,
  input  logic             o_ack
);

  // Occupancy flags and the two result registers.
  logic             out_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] skid_data;

  logic [WIDTH-1:0] sum;
  logic             in_xfer;
  logic             out_xfer;

  // Carry-out falls off the top: the sum is taken modulo 2^WIDTH.
  assign sum = i_data + i_datb;

  // Ready only depends on the skid flag; the rst term drops it at once
  // while reset is held, without waiting for a clock.
  assign i_ack = rst & ~skid_valid;

  assign o_req  = out_valid;
  assign o_datc = out_data;

  assign in_xfer  = i_req & i_ack;
  assign out_xfer = out_valid & o_ack;

  // Occupancy update: fill output first, spill to skid when stalled,
  // refill output from skid on an emit, empty output when nothing follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else begin
      if (skid_valid) begin
        // i_ack is 0 here, so no new pair can arrive this edge.
        if (out_xfer) begin
          out_data   <= skid_data;
          skid_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        if (!out_valid || out_xfer) begin
          out_data  <= sum;
          out_valid <= 1'b1;
        end else begin
          skid_data  <= sum;
          skid_valid <= 1'b1;
        end
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Directed bench for the adder: a driver issues operand pairs and pushes
// the hand-computed sum when the pair is accepted; an independent monitor
// pops and compares whenever the DUT emits a word.
module tb_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         i_req;
  logic [W-1:0] i_data;
  logic [W-1:0] i_datb;
  logic         i_ack;
  logic         o_req;
  logic [W-1:0] o_datc;
  logic         o_ack;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           acc_cnt = 0;
  int           out_cnt = 0;
  int           cyc = 0;

  adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_data (i_data),
    .i_datb (i_datb),
    .i_ack  (i_ack),
    .o_req  (o_req),
    .o_datc (o_datc),
    .o_ack  (o_ack)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  // Sampled on the falling edge: a word seen here with o_req&o_ack moves
  // at the next rising edge.
  always @(negedge clk) begin
    if (rst && o_req && o_ack) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got=%h expected=none at %0t", o_datc, $time);
      end else begin
        check("scoreboard", o_datc, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a pair until accepted, records its expected sum, then returns
  // just after the accepting edge with i_req low.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e);
    int waited = 0;
    i_req  = 1'b1;
    i_data = a;
    i_datb = b;
    @(negedge clk);
    while (!i_ack && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!i_ack) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got=i_ack 0 expected=i_ack 1 at %0t", $time);
    end else begin
      exp_q.push_back(e);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
  endtask

  // Lets the DUT emit everything outstanding.
  task automatic drain();
    int waited = 0;
    o_ack = 1'b1;
    while ((exp_q.size() != 0 || o_req) && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain_empty", W'(exp_q.size()), '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int a0;
    int o0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst    = 1'b0;
    i_req  = 1'b0;
    i_data = '0;
    i_datb = '0;
    o_ack  = 1'b0;

    // Reset state
    #12;
    check("reset_o_req", W'(o_req), '0);
    check("reset_i_ack", W'(i_ack), '0);
    check("reset_o_datc", o_datc, '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("post_reset_i_ack", W'(i_ack), 1);
    check("post_reset_o_req", W'(o_req), '0);
    next_cycle();

    // Basic add with one-cycle latency
    o_ack = 1'b1;
    send(32'h0000_0005, 32'h0000_0007, 32'h0000_000C);
    check("basic_o_req", W'(o_req), 1);
    check("basic_o_datc", o_datc, 32'h0000_000C);
    drain();

    // Wrap-around
    send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE);
    drain();

    // Backpressure: first pair to output register, second to skid
    o_ack = 1'b0;
    send(32'h1, 32'h1, 32'h2);
    send(32'h2, 32'h2, 32'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_i_ack_low", W'(i_ack), '0);
      check("bp_o_req_held", W'(o_req), 1);
      check("bp_o_datc_held", o_datc, 32'h2);
      next_cycle();
    end
    o_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_second_out", o_datc, 32'h4);
    check("bp_i_ack_back", W'(i_ack), 1);
    drain();

    // Streaming: one accepted pair per cycle with o_ack held high
    o_ack = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      ra = {1'b0, 31'($urandom())};
      rb = {1'b0, 31'($urandom())};
      send(ra, rb, ra + rb);
    end
    check("stream_cycles", W'(cyc - c0), 1000);
    drain();

    // Random o_ack and i_req
    a0 = acc_cnt;
    o0 = out_cnt;
    for (int i = 0; i < 600; i++) begin
      i_req  = 1'($urandom_range(0, 1));
      i_data = $urandom();
      i_datb = $urandom();
      o_ack  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i_req && i_ack) begin
        exp_q.push_back(i_data + i_datb);
        acc_cnt++;
      end
      next_cycle();
    end
    i_req = 1'b0;
    drain();
    check("random_count", W'(out_cnt - o0), W'(acc_cnt - a0));

    // Reset mid-stream with the skid register full
    o_ack = 1'b0;
    send(32'd10, 32'd20, 32'd30);
    send(32'd3, 32'd4, 32'd7);
    @(negedge clk);
    check("pre_reset_i_ack", W'(i_ack), '0);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_o_req", W'(o_req), '0);
    check("midreset_i_ack", W'(i_ack), '0);
    exp_q.delete();
    next_cycle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    next_cycle();
    o_ack = 1'b1;
    @(negedge clk);
    check("rerun_i_ack", W'(i_ack), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_o_req", W'(o_req), '0);
    end
    next_cycle();
    send(32'd100, 32'd23, 32'd123);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
